// File: rtl/drive_pkg.sv
// drive_pkg: shared enums, state encoding and speed/turn-cap helpers for drive_speed_ctrl.
// Build option DRIVE_ECO_EN: every table target is clamped to ECO_MAX (90 km/h).
package drive_pkg;

  typedef enum logic [2:0] {
    BB_NONE     = 3'b000,
    BB_RED      = 3'b001,
    BB_YELLOW   = 3'b010,
    BB_GREEN    = 3'b011,
    BB_OBSTACLE = 3'b100,
    BB_LEFT     = 3'b101,
    BB_RIGHT    = 3'b110,
    BB_RSVD     = 3'b111
  } bb_e;

  typedef enum logic [2:0] {
    GPS_ALLEY     = 3'b000,
    GPS_ROAD_1_3  = 3'b001,
    GPS_ROAD_4P   = 3'b010,
    GPS_MOTORWAY  = 3'b011,
    GPS_HWY_1LANE = 3'b100,
    GPS_HWY_L3P   = 3'b101,
    GPS_HWY_L2    = 3'b110,
    GPS_HWY_L1    = 3'b111
  } gps_e;

  typedef enum logic [1:0] {
    H_STRAIGHT = 2'b00,
    H_LEFT     = 2'b01,
    H_RIGHT    = 2'b10
  } handle_e;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_CRUISE = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_ABORT  = 3'd4
  } drv_state_e;

  localparam int ECO_MAX = 9;

  // Road-class speed target, saturated to what an spd_w-bit engine code can hold.
  function automatic int tgt_speed(gps_e gps, int spd_w);
    int v;
    int lim;
    case (gps)
      GPS_ALLEY:     v = 1;
      GPS_ROAD_1_3:  v = 4;
      GPS_ROAD_4P:   v = 5;
      GPS_MOTORWAY:  v = 8;
      GPS_HWY_1LANE: v = 8;
      GPS_HWY_L3P:   v = 10;
      GPS_HWY_L2:    v = 11;
      default:       v = 12;
    endcase
`ifdef DRIVE_ECO_EN
    if (v > ECO_MAX) v = ECO_MAX;
`endif
    lim = (1 << spd_w) - 1;
    if (v > lim) v = lim;
    return v;
  endfunction

  // Speed allowed while turning: right 1, left 2 (1 in an alley).
  function automatic int turn_cap(logic right, gps_e gps, int spd_w);
    int v;
    int lim;
    if (right) v = 1;
    else if (gps == GPS_ALLEY) v = 1;
    else v = 2;
    lim = (1 << spd_w) - 1;
    if (v > lim) v = lim;
    return v;
  endfunction

  function automatic logic is_stop(bb_e bb);
    return (bb == BB_RED) || (bb == BB_YELLOW) || (bb == BB_OBSTACLE);
  endfunction

  function automatic logic is_go(bb_e bb);
    return (bb == BB_NONE) || (bb == BB_GREEN) || (bb == BB_RSVD);
  endfunction

endpackage

// File: rtl/drive_ramp_step.sv
// drive_ramp_step: prescaled up/down saturating speed register.
// Steps one code toward i_tgt every UP_DIV (rising) or DN_DIV (falling) cycles;
// i_clr forces zero, i_cap_en clamps the speed to i_cap at once.
module drive_ramp_step #(
  parameter int SPD_W  = 4,
  parameter int UP_DIV = 8,
  parameter int DN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_cap_en,
  input  logic [SPD_W-1:0] i_cap,
  input  logic             i_run,
  input  logic [SPD_W-1:0] i_tgt,
  output logic [SPD_W-1:0] o_speed
);
  localparam int MAX_DIV = (UP_DIV > DN_DIV) ? UP_DIV : DN_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_div_last;
  logic [SPD_W-1:0] r_speed;
  logic [SPD_W-1:0] w_speed_next;

  // Next speed/prescaler: clear beats cap beats ramp; >= lets a direction change never stall.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_speed_next = r_speed;
    w_div_last   = (i_tgt > r_speed) ? CNT_W'(UP_DIV - 1) : CNT_W'(DN_DIV - 1);
    if (i_clr) begin
      w_cnt_next   = '0;
      w_speed_next = '0;
    end else if (i_cap_en) begin
      w_cnt_next   = '0;
      w_speed_next = (r_speed > i_cap) ? i_cap : r_speed;
    end else if (i_run) begin
      if (r_speed == i_tgt) begin
        w_cnt_next = '0;
      end else if (r_cnt >= w_div_last) begin
        w_cnt_next   = '0;
        w_speed_next = (i_tgt > r_speed) ? r_speed + 1'b1 : r_speed - 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // Speed and prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_speed <= '0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_speed <= w_speed_next;
    end
  end

  assign o_speed = r_speed;

endmodule

// File: rtl/drive_speed_ctrl.sv
// drive_speed_ctrl: mode FSM (HALT/CRUISE/TURN_L/TURN_R/ABORT), turn timer and
// debounced restart driving handle/engine from blackbox vision and gps road class.
// Build option DRIVE_ECO_EN: targets clamped to 9 and acceleration divider doubled.
module drive_speed_ctrl
  import drive_pkg::*;
#(
  parameter int SPD_W     = 4,
  parameter int RAMP_DIV  = 8,
  parameter int DECEL_DIV = 2,
  parameter int TURN_CYC  = 16,
  parameter int STOP_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       blackbox,
  input  logic [2:0]       gps,
  output logic [1:0]       handle,
  output logic [SPD_W-1:0] engine,
  output logic [2:0]       state_o,
  output logic             turn_busy
);
`ifdef DRIVE_ECO_EN
  localparam int ACC_DIV = 2 * RAMP_DIV;
`else
  localparam int ACC_DIV = RAMP_DIV;
`endif
  localparam int TURN_W = $clog2(TURN_CYC) + 1;
  localparam int HOLD_W = $clog2(STOP_HOLD) + 1;

  drv_state_e        r_state, w_state_next;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_cnt_next;
  logic [HOLD_W-1:0] r_hold, w_hold_next;
  logic [1:0]        r_handle;
  handle_e           w_handle_next;
  logic              r_turn_busy, w_turn_busy_next;

  bb_e               w_bb;
  gps_e              w_gps;
  logic              w_stop, w_go;
  logic [SPD_W-1:0]  w_table_tgt, w_cap_l, w_cap_r;
  logic              w_ramp_clr, w_ramp_cap_en, w_ramp_run;
  logic [SPD_W-1:0]  w_ramp_tgt, w_ramp_cap;

  assign w_bb        = bb_e'(blackbox);
  assign w_gps       = gps_e'(gps);
  assign w_stop      = is_stop(w_bb);
  assign w_go        = is_go(w_bb);
  assign w_table_tgt = SPD_W'(tgt_speed(w_gps, SPD_W));
  assign w_cap_l     = SPD_W'(turn_cap(1'b0, w_gps, SPD_W));
  assign w_cap_r     = SPD_W'(turn_cap(1'b1, w_gps, SPD_W));

  // Next state, timers and ramp controls; a stop code overrides every state.
  always_comb begin
    w_state_next    = r_state;
    w_turn_cnt_next = r_turn_cnt;
    w_hold_next     = '0;
    w_ramp_clr      = 1'b0;
    w_ramp_cap_en   = 1'b0;
    w_ramp_run      = 1'b0;
    w_ramp_tgt      = w_table_tgt;
    w_ramp_cap      = w_cap_l;
    if (w_stop) begin
      w_state_next    = ST_ABORT;
      w_turn_cnt_next = '0;
      w_ramp_clr      = 1'b1;
    end else begin
      case (r_state)
        ST_HALT: begin
          w_ramp_clr = 1'b1;
          if (w_go) begin
            if (r_hold == HOLD_W'(STOP_HOLD - 1)) w_state_next = ST_CRUISE;
            else w_hold_next = r_hold + 1'b1;
          end
        end
        ST_CRUISE: begin
          if (w_bb == BB_LEFT) begin
            w_state_next    = ST_TURN_L;
            w_turn_cnt_next = TURN_W'(TURN_CYC - 1);
            w_ramp_cap_en   = 1'b1;
            w_ramp_cap      = w_cap_l;
          end else if (w_bb == BB_RIGHT) begin
            w_state_next    = ST_TURN_R;
            w_turn_cnt_next = TURN_W'(TURN_CYC - 1);
            w_ramp_cap_en   = 1'b1;
            w_ramp_cap      = w_cap_r;
          end else begin
            w_ramp_run = 1'b1;
          end
        end
        ST_TURN_L, ST_TURN_R: begin
          w_ramp_run = 1'b1;
          w_ramp_tgt = (r_state == ST_TURN_L) ? w_cap_l : w_cap_r;
          if (r_turn_cnt == '0) w_state_next = ST_CRUISE;
          else w_turn_cnt_next = r_turn_cnt - 1'b1;
        end
        default: begin
          w_ramp_clr   = 1'b1;
          w_state_next = ST_HALT;
        end
      endcase
    end
    w_handle_next    = H_STRAIGHT;
    w_turn_busy_next = 1'b0;
    if (w_state_next == ST_TURN_L) begin
      w_handle_next    = H_LEFT;
      w_turn_busy_next = 1'b1;
    end else if (w_state_next == ST_TURN_R) begin
      w_handle_next    = H_RIGHT;
      w_turn_busy_next = 1'b1;
    end
  end

  // FSM state, turn timer, restart debounce and registered handle/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HALT;
      r_turn_cnt  <= '0;
      r_hold      <= '0;
      r_handle    <= H_STRAIGHT;
      r_turn_busy <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_turn_cnt  <= w_turn_cnt_next;
      r_hold      <= w_hold_next;
      r_handle    <= w_handle_next;
      r_turn_busy <= w_turn_busy_next;
    end
  end

  drive_ramp_step #(
    .SPD_W  (SPD_W),
    .UP_DIV (ACC_DIV),
    .DN_DIV (DECEL_DIV)
  ) u_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_ramp_clr),
    .i_cap_en (w_ramp_cap_en),
    .i_cap    (w_ramp_cap),
    .i_run    (w_ramp_run),
    .i_tgt    (w_ramp_tgt),
    .o_speed  (engine)
  );

  assign handle    = r_handle;
  assign state_o   = r_state;
  assign turn_busy = r_turn_busy;

endmodule
